fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
// - Front end of the processor. Owns the program counter and issues instruction-memory reads.
// - Delivers instructions to decode as {instr, instr_pc, instr_valid}.
// - Consumes branch resolution: the branch unit computes next_pc from instr_pc; a taken result arrives here as a redirect.
// - Sequential PC with wrap-around, 1-cycle-latency memory, 1-entry skid buffer under decode stall, redirect flush.
// PARAMETERS
// - ADDRESS_WIDTH  6  PC is [ADDRESS_WIDTH:0] (7 bits, word-addressed); matches branch unit pc/next_pc width
// - RESET_PC       0  fetch_pc value on reset; width ADDRESS_WIDTH+1
// PORTS
// - clk             in   1       clock, all state on posedge
// - rst             in   1       reset, asynchronous, active-high
// - stall           in   1       decode cannot accept; hold instr outputs
// - redirect_valid  in   1       branch taken; flush and refetch
// - redirect_pc     in   AW+1    redirect target (branch unit next_pc)
// - imem_req        out  1       read strobe
// - imem_addr       out  AW+1    read address (registered fetch_pc)
// - imem_rdata      in   32      read data, valid the cycle after imem_req
// - instr           out  32      instruction to decode
// - instr_pc        out  AW+1    PC of instr
// - instr_valid     out  1       instr/instr_pc meaningful
// - halted          out  1       halt reached (tied 0 without FETCH_HALT_EN)
// BEHAVIOUR
// - Reset values:
//   - fetch_pc = RESET_PC; state = BOOT
//   - instr = 0, instr_pc = 0, instr_valid = 0; skid and in-flight flags = 0; halted = 0
// - States: BOOT -> RUN after exactly one cycle; RUN -> HALT (FETCH_HALT_EN only); HALT -> RUN on redirect_valid.
// - imem_req = (state == RUN) & !stall & !redirect_valid
//   - imem_addr = fetch_pc
//   - On req: fetch_pc <= fetch_pc + 1, modulo 2^(AW+1); max PC wraps to 0.
//   - Record in-flight tag = pc of the request.
// - Response (cycle after req):
//   - stall = 0: output stage <= {imem_rdata, tag}, instr_valid = 1.
//   - stall = 1: response stored in the skid buffer; outputs held.
// - Stall:
//   - Output stage holds exactly; no new req.
//   - At most one in-flight response, so the skid never overflows.
// - Stall release:
//   - If skid is valid, output <= skid and skid is cleared that same edge.
//   - A req may issue in the release cycle; its data lands one cycle later.
// - No-data cycle: stall = 0 with no response and no skid -> instr_valid <= 0.
// - Throughput: 1 instr/cycle in steady state with no stall.
// - Redirect (priority over stall and over HALT):
//   - On the redirect edge: instr_valid <= 0; skid cleared; in-flight response discarded; fetch_pc <= redirect_pc; no req.
//   - Redirect at cycle N: req at N+1 for redirect_pc; instr_valid with instr_pc = redirect_pc during N+3 (if not stalled).
// - Back-to-back redirects: the last one wins; each restarts the N+3 timing.
// - Reset mid-operation: all state returns to reset values immediately (async); in-flight data is ignored after release.
// CONFIGURATION
// - FETCH_HALT_EN defined:
//   - When an instr with instr[31:26] == 6'b111111 is presented with instr_valid, state -> HALT at that edge.
//   - HALT: imem_req = 0; later in-flight data discarded; halt instr stays on the outputs until stall drops, then instr_valid <= 0.
//   - halted = 1 in HALT. Redirect leaves HALT with the normal redirect timing.
// - FETCH_HALT_EN undefined:
//   - No HALT state; opcode 6'b111111 is passed through like any instr; halted tied 0.
// TESTING
// - Reset release, RESET_PC = 0, stall = 0, memory returns 32'h1000_0000 + addr:
//   - imem_req high from cycle 2; instr_pc = 0, 1, 2, ... on consecutive cycles.
//   - instr = 32'h1000_0000 + instr_pc.
// - Stall for 3 cycles at steady state, current output instr_pc = 5:
//   - Outputs hold pc 5 throughout; pc 6 captured in skid; no req while stalled.
//   - After release: pc 6, then 7, 8; no skip, no duplicate.
// - Redirect to 7'd40 while instr_pc = 10:
//   - instr_valid = 0 for two cycles, then instr_pc = 40, 41.
//   - pc 11/12 never appear on the outputs.
// - Redirect asserted while stall = 1 with skid full:
//   - Skid dropped; first valid after stall drops is redirect_pc; skid content never delivered.
// - Wrap: RESET_PC = 7'd126 -> instr_pc sequence 126, 127, 0, 1.
// - FETCH_HALT_EN: memory word at pc 3 = 32'hFC00_0000:
//   - halted = 1 after pc 3 is presented; imem_req stays 0.
//   - Later redirect to pc 0 restarts fetch; halted = 0.

Source files
------------

// File: rtl/fetch_if.sv
// fetch_if: decode/branch/imem signals between fetch_unit (master) and its environment (slave).
interface fetch_if #(parameter int ADDRESS_WIDTH = 6);
   logic                     stall;
   logic                     redirect_valid;
   logic [ADDRESS_WIDTH:0]   redirect_pc;
   logic                     imem_req;
   logic [ADDRESS_WIDTH:0]   imem_addr;
   logic [31:0]              imem_rdata;
   logic [31:0]              instr;
   logic [ADDRESS_WIDTH:0]   instr_pc;
   logic                     instr_valid;
   logic                     halted;
   modport master (
      input  stall, redirect_valid, redirect_pc, imem_rdata,
      output imem_req, imem_addr, instr, instr_pc, instr_valid, halted
   );
   modport slave (
      output stall, redirect_valid, redirect_pc, imem_rdata,
      input  imem_req, imem_addr, instr, instr_pc, instr_valid, halted
   );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner issuing 1-cycle-latency imem reads, with a 1-entry skid under stall and redirect flush.
// Defining FETCH_HALT_EN adds a HALT state entered when opcode 6'b111111 is presented.
module fetch_unit #(
   parameter int                     ADDRESS_WIDTH = 6,
   parameter logic [ADDRESS_WIDTH:0] RESET_PC      = '0
) (
   input logic      clk,
   input logic      rst,
   fetch_if.master  bus
);
   localparam int PW = ADDRESS_WIDTH + 1;
`ifdef FETCH_HALT_EN
   typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;
`else
   typedef enum logic {BOOT, RUN} state_t;
`endif
   state_t        state_q, state_d;
   logic [PW-1:0] pc_q, pc_d, tag_q, tag_d, ipc_q, ipc_d, skid_pc_q, skid_pc_d;
   logic [31:0]   instr_q, instr_d, skid_q, skid_d;
   logic          ival_q, ival_d, skid_v_q, skid_v_d, infl_q, infl_d, req;

   assign req = state_q == RUN && !bus.stall && !bus.redirect_valid;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= BOOT;
         pc_q      <= RESET_PC;
         tag_q     <= '0;
         ipc_q     <= '0;
         skid_pc_q <= '0;
         instr_q   <= '0;
         skid_q    <= '0;
         ival_q    <= 1'b0;
         skid_v_q  <= 1'b0;
         infl_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         tag_q     <= tag_d;
         ipc_q     <= ipc_d;
         skid_pc_q <= skid_pc_d;
         instr_q   <= instr_d;
         skid_q    <= skid_d;
         ival_q    <= ival_d;
         skid_v_q  <= skid_v_d;
         infl_q    <= infl_d;
      end
   end

   always_comb begin
      state_d   = state_q == BOOT ? RUN : state_q;
      pc_d      = req ? pc_q + PW'(1) : pc_q;
      tag_d     = req ? pc_q : tag_q;
      infl_d    = req;
      instr_d   = instr_q;
      ipc_d     = ipc_q;
      ival_d    = ival_q;
      skid_d    = skid_q;
      skid_pc_d = skid_pc_q;
      skid_v_d  = skid_v_q;
      if (bus.redirect_valid) begin
         state_d  = RUN;
         pc_d     = bus.redirect_pc;
         ival_d   = 1'b0;
         skid_v_d = 1'b0;
         infl_d   = 1'b0;
      end
`ifdef FETCH_HALT_EN
      // Halt edge and HALT itself: any fetched-ahead data is dropped, halt instr held only while stalled
      else if (state_q == HALT || (state_q == RUN && ival_q && instr_q[31:26] == 6'h3f)) begin
         state_d  = HALT;
         skid_v_d = 1'b0;
         ival_d   = bus.stall ? ival_q : 1'b0;
      end
`endif
      else if (bus.stall) begin
         skid_d    = infl_q ? bus.imem_rdata : skid_q;
         skid_pc_d = infl_q ? tag_q : skid_pc_q;
         skid_v_d  = skid_v_q | infl_q;
      end else if (skid_v_q) begin
         instr_d  = skid_q;
         ipc_d    = skid_pc_q;
         ival_d   = 1'b1;
         skid_v_d = 1'b0;
      end else begin
         instr_d = infl_q ? bus.imem_rdata : instr_q;
         ipc_d   = infl_q ? tag_q : ipc_q;
         ival_d  = infl_q;
      end
   end

   assign bus.imem_req    = req;
   assign bus.imem_addr   = pc_q;
   assign bus.instr       = instr_q;
   assign bus.instr_pc    = ipc_q;
   assign bus.instr_valid = ival_q;
`ifdef FETCH_HALT_EN
   assign bus.halted = state_q == HALT;
`else
   assign bus.halted = 1'b0;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of sequencing, stall/skid, redirect, halt and wrap for fetch_unit.
module tb_fetch_unit;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        halt_word = 1'b0;
   int          total = 0;
   int          bad = 0;
   logic [39:0] out1, out2;

   always #5 clk = ~clk;

   fetch_if #(.ADDRESS_WIDTH(6)) bus ();
   fetch_if #(.ADDRESS_WIDTH(6)) bus2 ();

   fetch_unit #(.ADDRESS_WIDTH(6), .RESET_PC(7'd0)) dut (.clk(clk), .rst(rst), .bus(bus.master));
   fetch_unit #(.ADDRESS_WIDTH(6), .RESET_PC(7'd126)) dut2 (.clk(clk), .rst(rst), .bus(bus2.master));

   assign out1 = {bus.instr_valid, bus.instr_pc, bus.instr};
   assign out2 = {bus2.instr_valid, bus2.instr_pc, bus2.instr};

   function automatic logic [31:0] word(input logic [6:0] a);
      return (halt_word && a == 7'd3) ? 32'hFC00_0000 : 32'h1000_0000 + {25'd0, a};
   endfunction

   function automatic logic [39:0] vo(input logic [6:0] p);
      return {1'b1, p, 32'h1000_0000 + {25'd0, p}};
   endfunction

   always @(posedge clk) begin
      bus.imem_rdata  <= bus.imem_req ? word(bus.imem_addr) : 32'hDEAD_BEEF;
      bus2.imem_rdata <= bus2.imem_req ? word(bus2.imem_addr) : 32'hDEAD_BEEF;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      bus.stall = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc = '0;
      bus2.stall = 1'b0;
      bus2.redirect_valid = 1'b0;
      bus2.redirect_pc = '0;
      repeat (2) tick();
      total++;
      if ({out1, bus.imem_req, bus.halted} !== 42'd0) begin
         bad++;
         $display("FAIL reset_outputs got=%h exp=0", {out1, bus.imem_req, bus.halted});
      end
      rst = 1'b0;
      #1;
      total++;
      if (bus.imem_req !== 1'b0) begin
         bad++;
         $display("FAIL boot_no_req got=%b exp=0", bus.imem_req);
      end
   endtask

   task automatic test_sequential;
      tick();
      total++;
      if ({bus.imem_req, bus.imem_addr} !== {1'b1, 7'd0}) begin
         bad++;
         $display("FAIL first_req got=%h exp=%h", {bus.imem_req, bus.imem_addr}, {1'b1, 7'd0});
      end
      repeat (2) tick();
      for (int i = 0; i < 5; i++) begin
         total++;
         if (out1 !== vo(7'(i))) begin
            bad++;
            $display("FAIL seq_pc%0d got=%h exp=%h", i, out1, vo(7'(i)));
         end
         tick();
      end
   endtask

   task automatic test_stall;
      bus.stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         total++;
         if ({out1, bus.imem_req} !== {vo(7'd5), 1'b0}) begin
            bad++;
            $display("FAIL stall_hold%0d got=%h exp=%h", i, {out1, bus.imem_req}, {vo(7'd5), 1'b0});
         end
         tick();
      end
      bus.stall = 1'b0;
      #1;
      total++;
      if ({out1, bus.imem_req, bus.imem_addr} !== {vo(7'd5), 1'b1, 7'd7}) begin
         bad++;
         $display("FAIL stall_release got=%h exp=%h", {out1, bus.imem_req, bus.imem_addr}, {vo(7'd5), 1'b1, 7'd7});
      end
      for (int p = 6; p < 9; p++) begin
         tick();
         total++;
         if (out1 !== vo(7'(p))) begin
            bad++;
            $display("FAIL after_stall_pc%0d got=%h exp=%h", p, out1, vo(7'(p)));
         end
      end
      tick();
   endtask

   task automatic test_redirect;
      tick();
      total++;
      if (out1 !== vo(7'd10)) begin
         bad++;
         $display("FAIL pre_redirect got=%h exp=%h", out1, vo(7'd10));
      end
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 7'd40;
      #1;
      total++;
      if (bus.imem_req !== 1'b0) begin
         bad++;
         $display("FAIL redirect_no_req got=%b exp=0", bus.imem_req);
      end
      tick();
      bus.redirect_valid = 1'b0;
      #1;
      total++;
      if ({bus.instr_valid, bus.imem_req, bus.imem_addr} !== {1'b0, 1'b1, 7'd40}) begin
         bad++;
         $display("FAIL redirect_req got=%h exp=%h", {bus.instr_valid, bus.imem_req, bus.imem_addr}, {1'b0, 1'b1, 7'd40});
      end
      tick();
      total++;
      if (bus.instr_valid !== 1'b0) begin
         bad++;
         $display("FAIL redirect_gap got=%b exp=0", bus.instr_valid);
      end
      for (int p = 40; p < 42; p++) begin
         tick();
         total++;
         if (out1 !== vo(7'(p))) begin
            bad++;
            $display("FAIL redirect_pc%0d got=%h exp=%h", p, out1, vo(7'(p)));
         end
      end
   endtask

   task automatic test_redirect_stall;
      tick();
      bus.stall = 1'b1;
      tick();
      total++;
      if (out1 !== vo(7'd42)) begin
         bad++;
         $display("FAIL rs_hold got=%h exp=%h", out1, vo(7'd42));
      end
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 7'd20;
      tick();
      bus.redirect_valid = 1'b0;
      #1;
      total++;
      if ({bus.instr_valid, bus.imem_req} !== 2'b00) begin
         bad++;
         $display("FAIL rs_flushed got=%b exp=00", {bus.instr_valid, bus.imem_req});
      end
      bus.stall = 1'b0;
      #1;
      total++;
      if ({bus.instr_valid, bus.imem_req, bus.imem_addr} !== {1'b0, 1'b1, 7'd20}) begin
         bad++;
         $display("FAIL rs_req got=%h exp=%h", {bus.instr_valid, bus.imem_req, bus.imem_addr}, {1'b0, 1'b1, 7'd20});
      end
      tick();
      total++;
      if (bus.instr_valid !== 1'b0) begin
         bad++;
         $display("FAIL rs_gap got=%b exp=0", bus.instr_valid);
      end
      for (int p = 20; p < 22; p++) begin
         tick();
         total++;
         if (out1 !== vo(7'(p))) begin
            bad++;
            $display("FAIL rs_pc%0d got=%h exp=%h", p, out1, vo(7'(p)));
         end
      end
   endtask

   task automatic test_back_to_back;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 7'd50;
      tick();
      bus.redirect_pc = 7'd60;
      tick();
      bus.redirect_valid = 1'b0;
      #1;
      total++;
      if ({bus.instr_valid, bus.imem_req, bus.imem_addr} !== {1'b0, 1'b1, 7'd60}) begin
         bad++;
         $display("FAIL b2b_req got=%h exp=%h", {bus.instr_valid, bus.imem_req, bus.imem_addr}, {1'b0, 1'b1, 7'd60});
      end
      tick();
      total++;
      if (bus.instr_valid !== 1'b0) begin
         bad++;
         $display("FAIL b2b_gap got=%b exp=0", bus.instr_valid);
      end
      for (int p = 60; p < 62; p++) begin
         tick();
         total++;
         if (out1 !== vo(7'(p))) begin
            bad++;
            $display("FAIL b2b_pc%0d got=%h exp=%h", p, out1, vo(7'(p)));
         end
      end
   endtask

   task automatic test_halt;
      halt_word = 1'b1;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 7'd0;
      tick();
      bus.redirect_valid = 1'b0;
      repeat (2) tick();
      for (int p = 0; p < 3; p++) begin
         total++;
         if (out1 !== vo(7'(p))) begin
            bad++;
            $display("FAIL halt_pre_pc%0d got=%h exp=%h", p, out1, vo(7'(p)));
         end
         tick();
      end
      total++;
      if ({out1, bus.halted} !== {1'b1, 7'd3, 32'hFC00_0000, 1'b0}) begin
         bad++;
         $display("FAIL halt_word got=%h exp=%h", {out1, bus.halted}, {1'b1, 7'd3, 32'hFC00_0000, 1'b0});
      end
      tick();
`ifdef FETCH_HALT_EN
      for (int i = 0; i < 2; i++) begin
         total++;
         if ({bus.instr_valid, bus.halted, bus.imem_req} !== 3'b010) begin
            bad++;
            $display("FAIL halted%0d got=%b exp=010", i, {bus.instr_valid, bus.halted, bus.imem_req});
         end
         tick();
      end
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 7'd0;
      tick();
      bus.redirect_valid = 1'b0;
      #1;
      total++;
      if ({bus.halted, bus.imem_req, bus.imem_addr} !== {1'b0, 1'b1, 7'd0}) begin
         bad++;
         $display("FAIL unhalt_req got=%h exp=%h", {bus.halted, bus.imem_req, bus.imem_addr}, {1'b0, 1'b1, 7'd0});
      end
      repeat (2) tick();
      total++;
      if (out1 !== vo(7'd0)) begin
         bad++;
         $display("FAIL unhalt_pc0 got=%h exp=%h", out1, vo(7'd0));
      end
`else
      for (int p = 4; p < 6; p++) begin
         total++;
         if ({out1, bus.halted} !== {vo(7'(p)), 1'b0}) begin
            bad++;
            $display("FAIL passthru_pc%0d got=%h exp=%h", p, {out1, bus.halted}, {vo(7'(p)), 1'b0});
         end
         tick();
      end
`endif
   endtask

   task automatic test_wrap;
      rst = 1'b1;
      #1;
      total++;
      if ({out1, bus.imem_req} !== 41'd0) begin
         bad++;
         $display("FAIL async_reset got=%h exp=0", {out1, bus.imem_req});
      end
      tick();
      rst = 1'b0;
      repeat (3) tick();
      total++;
      if (out1 !== vo(7'd0)) begin
         bad++;
         $display("FAIL restart_pc0 got=%h exp=%h", out1, vo(7'd0));
      end
      for (int i = 0; i < 4; i++) begin
         total++;
         if (out2 !== vo(7'(126 + i))) begin
            bad++;
            $display("FAIL wrap%0d got=%h exp=%h", i, out2, vo(7'(126 + i)));
         end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_stall();
      test_redirect();
      test_redirect_stall();
      test_back_to_back();
      test_halt();
      test_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
